// File: rtl/game_pkg.sv
// game_pkg: game-wide types and screen constants shared by the sequencer, box register and obstacle logic.
package game_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DEAD} state_t;
    localparam int SCREEN_H = 120;
    localparam logic [6:0] DEF_Y_CEIL = 7'd0;
    localparam logic [6:0] DEF_Y_FLOOR = 7'(SCREEN_H - 1);
    localparam int SCORE_W = 8;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running modulo-TICK_DIV counter with a synchronous clear and a wrap pulse.
module tick_divider #(
    parameter int TICK_DIV = 833333,
    localparam int CW = $clog2(TICK_DIV)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          tick_out
);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        tick_out = count_q == LAST;
        count_d = (clear || tick_out) ? '0 : count_q + 1'b1;
        count = count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else count_q <= count_d;
    end
endmodule

// File: rtl/flight_sequencer.sv
// flight_sequencer: game tick generation, tap queueing, IDLE/LOAD/RUN/DEAD flow and scoring.
module flight_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV = 833333,
    parameter int SCORE_TICKS = 60,
    parameter int DEAD_HOLD = 90,
    parameter logic [6:0] Y_CEIL = DEF_Y_CEIL,
    parameter logic [6:0] Y_FLOOR = DEF_Y_FLOOR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tap_level,
    input  logic [6:0]         box_y,
    input  logic               hit,
    output logic               tick,
    output logic               flap,
    output logic               box_load,
    output logic               running,
    output logic               game_over,
    output logic [SCORE_W-1:0] score
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCORE_TICKS + 1);
    localparam int HW = $clog2(DEAD_HOLD + 2);
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCORE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_DONE = HW'(DEAD_HOLD);

    state_t             state_q, state_d;
    logic               tap_prev_q, tap_prev_d;
    logic               pending_q, pending_d;
    logic [SW-1:0]      sub_q, sub_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [CW-1:0]      div_count;
    logic               div_tick, div_clear, tap_edge, death, hold_done;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .clock    (clock),
        .reset    (reset),
        .clear    (div_clear),
        .count    (div_count),
        .tick_out (div_tick)
    );

    always_comb begin
        tap_edge = tap_level & ~tap_prev_q;
        death = hit | (box_y <= Y_CEIL) | (box_y >= Y_FLOOR);
        hold_done = hold_q == HOLD_DONE;
        div_clear = state_q == IDLE || state_q == LOAD;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (tap_edge) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN: if (death) state_d = DEAD;
            DEAD: if (hold_done && tap_edge) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tick = state_q == RUN && div_count == DIV_LAST;
        flap = tick & (pending_q | tap_edge);
        box_load = state_q == LOAD;
        running = state_q == RUN;
        game_over = state_q == DEAD;
        score = score_q;
    end

    // A tick consumes the queued tap; taps outside RUN are never queued.
    always_comb begin
        tap_prev_d = tap_level;
        pending_d = state_q == RUN && !tick && (pending_q || tap_edge);
        sub_d = state_q == LOAD ? '0 : tick ? (sub_q == SUB_LAST ? '0 : sub_q + 1'b1) : sub_q;
        score_d = state_q == LOAD ? '0
                : (tick && sub_q == SUB_LAST && score_q != '1) ? score_q + 1'b1 : score_q;
        hold_d = state_q != DEAD ? '0 : (div_tick && !hold_done) ? hold_q + 1'b1 : hold_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tap_prev_q <= 1'b1;
            pending_q <= 1'b0;
            sub_q <= '0;
            hold_q <= '0;
            score_q <= '0;
        end else begin
            tap_prev_q <= tap_prev_d;
            pending_q <= pending_d;
            sub_q <= sub_d;
            hold_q <= hold_d;
            score_q <= score_d;
        end
    end
endmodule
